// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects, debug FSM states
// and default sizing.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF   = 5;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF        = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_forward_logic.sv
// Pure combinational forwarding selects and load-use / branch stall detection
// for the 5-stage pipeline.
module hazard_forward_logic
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rtE,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic [REG_ADDR_W-1:0] writeRegW,
  input  logic                  regWriteE,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  input  logic                  memToRegE,
  input  logic                  memToRegM,
  input  logic                  branchD,
  output logic [1:0]            fwd_ae_o,
  output logic [1:0]            fwd_be_o,
  output logic                  fwd_ad_o,
  output logic                  fwd_bd_o,
  output logic                  hz_o
);

  // Register $0 is hardwired to zero, so it never takes a forwarded value.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] wr_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] wr_w,
    input logic                  we_w
  );
    logic [1:0] sel;
    if ((src != '0) && (src == wr_m) && we_m) begin
      sel = FWD_MEM;
    end else if ((src != '0) && (src == wr_w) && we_w) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  logic lwstall_s;
  logic brstall_s;

  assign fwd_ae_o = fwd_sel(rsE, writeRegM, regWriteM, writeRegW, regWriteW);
  assign fwd_be_o = fwd_sel(rtE, writeRegM, regWriteM, writeRegW, regWriteW);
  assign fwd_ad_o = (rsD != '0) && (rsD == writeRegM) && regWriteM;
  assign fwd_bd_o = (rtD != '0) && (rtD == writeRegM) && regWriteM;

  assign lwstall_s = memToRegE && ((rtE == rsD) || (rtE == rtD));
  assign brstall_s = branchD &&
                     ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                      (memToRegM && ((writeRegM == rsD) || (writeRegM == rtD))));
  assign hz_o      = lwstall_s || brstall_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller with debug halt/single-step sequencer.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rtE,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic [REG_ADDR_W-1:0] writeRegW,
  input  logic                  regWriteE,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  input  logic                  memToRegE,
  input  logic                  memToRegM,
  input  logic                  branchD,
  input  logic                  pcSrcD,
  input  logic                  jumpD,
  input  logic                  dbg_halt_req,
  input  logic                  dbg_step,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushE,
  output logic                  clearD,
  output logic                  forwardAD,
  output logic                  forwardBD,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  dbg_halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  hz_state_e      state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           halted_q, halted_d;

  logic [1:0] fwd_ae_s, fwd_be_s;
  logic       fwd_ad_s, fwd_bd_s, hz_s;

  hazard_forward_logic #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeRegE (writeRegE),
    .writeRegM (writeRegM),
    .writeRegW (writeRegW),
    .regWriteE (regWriteE),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .memToRegE (memToRegE),
    .memToRegM (memToRegM),
    .branchD   (branchD),
    .fwd_ae_o  (fwd_ae_s),
    .fwd_be_o  (fwd_be_s),
    .fwd_ad_o  (fwd_ad_s),
    .fwd_bd_o  (fwd_bd_s),
    .hz_o      (hz_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stallF      = hz_s;
    stallD      = hz_s;
    flushE      = hz_s;
    clearD      = (pcSrcD || jumpD) && !hz_s;
    forwardAE   = fwd_ae_s;
    forwardBE   = fwd_be_s;
    forwardAD   = fwd_ad_s;
    forwardBD   = fwd_bd_s;
    case (state_q)
      RUN: begin
        if (dbg_halt_req) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
        clearD = 1'b0;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      HALTED: begin
        stallF    = 1'b1;
        stallD    = 1'b1;
        flushE    = 1'b1;
        clearD    = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        if (dbg_step) begin
          state_d = STEP;
        end else if (!dbg_halt_req) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      STEP: begin
        // The stepped instruction may itself stall; drain only once it has advanced.
        if (!hz_s) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = STEP;
        end
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = '0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  assign dbg_halted = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             run_step_s;

  assign run_step_s = (state_q == RUN) || (state_q == STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallF && run_step_s && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (clearD && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: forwarding, stalls,
// redirect squash, debug halt/step sequencing and asynchronous reset.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic       branchD, pcSrcD, jumpD, dbg_halt_req, dbg_step;
  logic       stallF, stallD, flushE, clearD, forwardAD, forwardBD, dbg_halted;
  logic [1:0] forwardAE, forwardBE;
  logic [31:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .pcSrcD(pcSrcD), .jumpD(jumpD),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .clearD(clearD),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .dbg_halted(dbg_halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clear_inputs();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeRegE = 5'd0; writeRegM = 5'd0; writeRegW = 5'd0;
    regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    memToRegE = 1'b0; memToRegM = 1'b0;
    branchD = 1'b0; pcSrcD = 1'b0; jumpD = 1'b0;
    dbg_halt_req = 1'b0; dbg_step = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string name, input logic [4:0] exp);
    // packs {stallF, stallD, flushE, clearD, dbg_halted}
    checks++;
    if ({stallF, stallD, flushE, clearD, dbg_halted} !== exp) begin
      errors++;
      $display("FAIL %s: got sF/sD/fE/cD/halt=%b want %b", name,
               {stallF, stallD, flushE, clearD, dbg_halted}, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if ({stallF, stallD, flushE, clearD, forwardAD, forwardBD, forwardAE, forwardBE, dbg_halted} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {stallF, stallD, flushE, clearD, forwardAD,
               forwardBD, forwardAE, forwardBE, dbg_halted});
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_ctl("post_reset_idle", 5'b00000);
  endtask

  task automatic test_forward();
    clear_inputs();
    rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1; writeRegW = 5'd3; regWriteW = 1'b1;
    #1;
    checks++;
    if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwdAE_mem: got %b want 10", forwardAE); end
    regWriteM = 1'b0;
    #1;
    checks++;
    if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwdAE_wb: got %b want 01", forwardAE); end
    clear_inputs();
    rtE = 5'd9; writeRegW = 5'd9; regWriteW = 1'b1; writeRegM = 5'd4; regWriteM = 1'b1;
    #1;
    checks++;
    if (forwardBE !== 2'b01 || forwardAE !== 2'b00) begin
      errors++; $display("FAIL fwdBE_wb: got AE=%b BE=%b want AE=00 BE=01", forwardAE, forwardBE);
    end
    clear_inputs();
    writeRegM = 5'd0; regWriteM = 1'b1; writeRegW = 5'd0; regWriteW = 1'b1;
    #1;
    checks++;
    if ({forwardAE, forwardBE, forwardAD, forwardBD} !== 6'b0) begin
      errors++; $display("FAIL fwd_r0: got %b want 000000", {forwardAE, forwardBE, forwardAD, forwardBD});
    end
    rtD = 5'd12; writeRegM = 5'd12;
    #1;
    checks++;
    if ({forwardAD, forwardBD} !== 2'b01) begin
      errors++; $display("FAIL fwdBD: got AD/BD=%b want 01", {forwardAD, forwardBD});
    end
  endtask

  task automatic test_lwstall();
    clear_inputs();
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    check_ctl("lwstall_hit", 5'b11100);
    rsD = 5'd6;
    #1;
    check_ctl("lwstall_miss", 5'b00000);
    rtD = 5'd5;
    #1;
    check_ctl("lwstall_rtD", 5'b11100);
  endtask

  task automatic test_brstall();
    clear_inputs();
    branchD = 1'b1; rsD = 5'd7; regWriteE = 1'b1; writeRegE = 5'd7;
    #1;
    check_ctl("brstall_E", 5'b11100);
    tick();
    regWriteE = 1'b0; writeRegE = 5'd0; writeRegM = 5'd7; regWriteM = 1'b1; memToRegM = 1'b0;
    #1;
    check_ctl("brstall_cleared", 5'b00000);
    checks++;
    if (forwardAD !== 1'b1) begin errors++; $display("FAIL br_fwdAD: got %b want 1", forwardAD); end
    memToRegM = 1'b1;
    #1;
    check_ctl("brstall_loadM", 5'b11100);
  endtask

  task automatic test_clear();
    clear_inputs();
    pcSrcD = 1'b1;
    #1;
    check_ctl("clear_pcsrc", 5'b00010);
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    check_ctl("clear_blocked", 5'b11100);
    clear_inputs();
    jumpD = 1'b1;
    #1;
    check_ctl("clear_jump", 5'b00010);
  endtask

  task automatic test_halt_step();
    clear_inputs();
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    #1;
    check_ctl("step_ignored_run", 5'b00000);
    dbg_halt_req = 1'b1;
    #1;
    check_ctl("halt_req_run", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl($sformatf("drain_%0d", i), 5'b11100);
    end
    tick();
    check_ctl("halted", 5'b11101);
    rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1;
    #1;
    checks++;
    if (forwardAE !== 2'b00) begin errors++; $display("FAIL halted_fwd: got %b want 00", forwardAE); end
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    #1;
    check_ctl("step_cycle", 5'b00000);
    checks++;
    if (forwardAE !== 2'b10) begin errors++; $display("FAIL step_fwd: got %b want 10", forwardAE); end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl($sformatf("step_drain_%0d", i), 5'b11100);
    end
    tick();
    check_ctl("step_halted", 5'b11101);
    dbg_halt_req = 1'b0;
    #1;
    check_ctl("halted_hold", 5'b11101);
    tick();
    check_ctl("resume_run", 5'b00000);
  endtask

  task automatic test_step_hazard();
    clear_inputs();
    dbg_halt_req = 1'b1;
    repeat (4) tick();
    check_ctl("sh_halted", 5'b11101);
    memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8; dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    #1;
    check_ctl("step_stalled", 5'b11100);
    tick();
    check_ctl("step_stalled_hold", 5'b11100);
    memToRegE = 1'b0;
    #1;
    check_ctl("step_released", 5'b00000);
    tick();
    check_ctl("step_then_drain", 5'b11100);
    dbg_halt_req = 1'b0;
    repeat (3) tick();
    check_ctl("sh_rehalted", 5'b11101);
    tick();
    check_ctl("sh_run", 5'b00000);
  endtask

  task automatic test_halt_mid_stall();
    clear_inputs();
    memToRegE = 1'b1; rtE = 5'd5; rsD = 5'd5; dbg_halt_req = 1'b1;
    #1;
    check_ctl("ms_stall", 5'b11100);
    tick();
    memToRegE = 1'b0; pcSrcD = 1'b1; dbg_halt_req = 1'b0;
    #1;
    check_ctl("ms_drain", 5'b11100);
    repeat (3) tick();
    check_ctl("ms_halted", 5'b11101);
    tick();
    check_ctl("ms_run", 5'b00010);
  endtask

  task automatic test_reset_mid_drain();
    clear_inputs();
    dbg_halt_req = 1'b1;
    tick();
    tick();
    check_ctl("rd_drain", 5'b11100);
    #2;
    rst = 1'b0;
    clear_inputs();
    #1;
    check_ctl("rd_async", 5'b00000);
    checks++;
    if ({forwardAE, forwardBE, forwardAD, forwardBD} !== 6'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rd_outputs: got fwd=%b stall_cnt=%0d flush_cnt=%0d want 0", 
               {forwardAE, forwardBE, forwardAD, forwardBD}, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_ctl("rd_run", 5'b00000);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_lwstall();
    test_brstall();
    test_clear();
    test_halt_step();
    test_step_hazard();
    test_halt_mid_stall();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
